// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and load results onto the single register-file
// write port. Loads have priority; ALU results that cannot go straight to the
// port wait in a small FIFO. A starve counter guarantees the FIFO head
// eventually drains under a continuous load stream.
// Optional feature: define WB_PERF_CNT_EN to add the retired_writes counter.
module writeback_arbiter #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 64,
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd_addr,
    input  logic [DATA_WIDTH-1:0] alu_rd_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_rd_addr,
    input  logic [DATA_WIDTH-1:0] ld_rd_data,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    output logic                  reg_write_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] clear_busy_addr
`ifdef WB_PERF_CNT_EN
    ,
    output logic [63:0]           retired_writes
`endif
);

    localparam int PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(ALU_FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(ALU_FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX    = STV_W'(STARVE_LIMIT);

    // Low-aligned load data widened to a full register; size 11 passes through.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [1:0]            size,
        input logic                  is_unsigned
    );
        logic fill;
        logic [DATA_WIDTH-1:0] result;
        case (size)
            2'b00: begin
                fill   = !is_unsigned && raw[7];
                result = {{(DATA_WIDTH-8){fill}}, raw[7:0]};
            end
            2'b01: begin
                fill   = !is_unsigned && raw[15];
                result = {{(DATA_WIDTH-16){fill}}, raw[15:0]};
            end
            2'b10: begin
                fill   = !is_unsigned && raw[31];
                result = {{(DATA_WIDTH-32){fill}}, raw[31:0]};
            end
            default: begin
                fill   = 1'b0;
                result = raw;
            end
        endcase
        return result;
    endfunction

    logic [ADDR_WIDTH-1:0] fifo_addr [ALU_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [ALU_FIFO_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic [STV_W-1:0]      starve_cnt;

    logic fifo_full;
    logic fifo_empty;
    logic starve_hit;
    logic ld_wr;
    logic fifo_pop;
    logic alu_keep;
    logic alu_bypass;
    logic fifo_push;

    logic                  wr_en_p0;
    logic [ADDR_WIDTH-1:0] wr_addr_p0;
    logic [DATA_WIDTH-1:0] wr_data_p0;

    // ---- stage p0: arbitration and handshakes ----
    // A load to x0 is consumed but does not occupy the port, so the FIFO
    // head may still drain that cycle.
    assign fifo_full  = (count == FIFO_FULL_CNT);
    assign fifo_empty = (count == '0);
    assign starve_hit = fifo_full && (starve_cnt == STARVE_MAX);
    assign ld_ready   = !starve_hit;
    assign ld_wr      = ld_valid && ld_ready && (ld_rd_addr != '0);
    assign fifo_pop   = !ld_wr && !fifo_empty;
    assign alu_ready  = !fifo_full || fifo_pop;
    assign alu_keep   = alu_valid && alu_ready && (alu_rd_addr != '0);
    assign alu_bypass = alu_keep && !ld_wr && fifo_empty;
    assign fifo_push  = alu_keep && !alu_bypass;

    // Select the single write for this cycle: load, then FIFO head, then bypass.
    always_comb begin
        wr_en_p0   = 1'b0;
        wr_addr_p0 = '0;
        wr_data_p0 = '0;
        if (ld_wr) begin
            wr_en_p0   = 1'b1;
            wr_addr_p0 = ld_rd_addr;
            wr_data_p0 = extend_load(ld_rd_data, ld_size, ld_unsigned);
        end else if (fifo_pop) begin
            wr_en_p0   = 1'b1;
            wr_addr_p0 = fifo_addr[head];
            wr_data_p0 = fifo_data[head];
        end else if (alu_bypass) begin
            wr_en_p0   = 1'b1;
            wr_addr_p0 = alu_rd_addr;
            wr_data_p0 = alu_rd_data;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_addr[tail] <= alu_rd_addr;
            fifo_data[tail] <= alu_rd_data;
        end
    end

    // FIFO pointers, occupancy and starve counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (fifo_pop) begin
                head <= head + PTR_W'(1);
            end
            if (fifo_push) begin
                tail <= tail + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (fifo_pop || !fifo_full) begin
                starve_cnt <= '0;
            end else if (ld_wr && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

    // ---- stage p1: registered write port ----
    // Write port register; address/data hold their last value between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_en    <= 1'b0;
            rd_addr         <= '0;
            rd_data         <= '0;
            clear_busy_addr <= '0;
        end else begin
            reg_write_en    <= wr_en_p0;
            clear_busy_addr <= wr_en_p0 ? wr_addr_p0 : '0;
            if (wr_en_p0) begin
                rd_addr <= wr_addr_p0;
                rd_data <= wr_data_p0;
            end
        end
    end

`ifdef WB_PERF_CNT_EN
    // Count every cycle the write strobe is high; wraps naturally at 2^64.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_writes <= '0;
        end else begin
            retired_writes <= retired_writes + 64'(reg_write_en);
        end
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vectors plus a queue-based reference
// model checked against the DUT on every cycle out of reset.
module tb_writeback_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic          clk;
    logic          reset;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd_addr;
    logic [DW-1:0] alu_rd_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd_addr;
    logic [DW-1:0] ld_rd_data;
    logic [1:0]    ld_size;
    logic          ld_unsigned;
    logic          reg_write_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] clear_busy_addr;
`ifdef WB_PERF_CNT_EN
    logic [63:0]   retired_writes;
`endif

    writeback_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd_addr(alu_rd_addr), .alu_rd_data(alu_rd_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_rd_addr(ld_rd_addr), .ld_rd_data(ld_rd_data),
        .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .reg_write_en(reg_write_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .clear_busy_addr(clear_busy_addr)
`ifdef WB_PERF_CNT_EN
        , .retired_writes(retired_writes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_ok = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    int            m_starve;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [63:0]   m_ret;

    function automatic logic [63:0] m_extend(input logic [63:0] d, input logic [1:0] size,
                                             input logic uns);
        int bits;
        logic [63:0] mask;
        logic [63:0] v;
        bits = 8 << size;
        mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        v = d & mask;
        if (!uns && bits < 64 && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_ld_ready();
        return !(mq.size() == DEPTH && m_starve == LIMIT);
    endfunction

    function automatic bit m_ld_writes();
        return ld_valid && m_ld_ready() && (ld_rd_addr != 0);
    endfunction

    function automatic bit m_alu_ready();
        return (mq.size() < DEPTH) || (!m_ld_writes() && mq.size() > 0);
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit   full, lw, pop, take, bypassed;
        ent_t e;
        if (!reset) begin
            mq.delete();
            m_starve = 0;
            m_en     = 0;
            m_addr   = '0;
            m_data   = '0;
            m_ret    = '0;
        end else begin
            m_ret    = m_ret + 64'(m_en);
            full     = (mq.size() == DEPTH);
            lw       = m_ld_writes();
            take     = alu_valid && m_alu_ready() && (alu_rd_addr != 0);
            pop      = !lw && (mq.size() > 0);
            bypassed = 0;
            m_en     = 0;
            if (lw) begin
                m_en   = 1;
                m_addr = ld_rd_addr;
                m_data = m_extend(ld_rd_data, ld_size, ld_unsigned);
            end else if (pop) begin
                e      = mq.pop_front();
                m_en   = 1;
                m_addr = e.a;
                m_data = e.d;
            end else if (take) begin
                m_en     = 1;
                m_addr   = alu_rd_addr;
                m_data   = alu_rd_data;
                bypassed = 1;
            end
            if (take && !bypassed) mq.push_back('{a: alu_rd_addr, d: alu_rd_data});
            if (pop || !full) m_starve = 0;
            else if (lw && m_starve < LIMIT) m_starve++;
        end
    end

    // Per-cycle compare of DUT against the model.
    always @(negedge clk) begin
        if (reset && model_ok) begin
            chk("m_wen", reg_write_en, m_en);
            chk("m_clear_busy", clear_busy_addr, m_en ? m_addr : '0);
            if (m_en) begin
                chk("m_rd_addr", rd_addr, m_addr);
                chk("m_rd_data", rd_data, m_data);
            end
            chk("m_alu_ready", alu_ready, m_alu_ready());
            chk("m_ld_ready", ld_ready, m_ld_ready());
`ifdef WB_PERF_CNT_EN
            chk("m_retired", retired_writes, m_ret);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ld(input logic [AW-1:0] a, input logic [63:0] d,
                            input logic [1:0] sz, input logic u);
        ld_valid = 1; ld_rd_addr = a; ld_rd_data = d; ld_size = sz; ld_unsigned = u;
    endtask

    task automatic drive_alu(input logic [AW-1:0] a, input logic [63:0] d);
        alu_valid = 1; alu_rd_addr = a; alu_rd_data = d;
    endtask

    task automatic idle(input int n);
        alu_valid = 0;
        ld_valid  = 0;
        repeat (n) cyc();
    endtask

    logic [1:0]  ev_sz [7] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
    logic        ev_u  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] ev_d  [7] = '{64'h80, 64'h80, 64'h7FFF_FFFF, 64'h1234_8001,
                               64'hAAAA_BBBB_8000_0000, 64'h8000_0000_0000_0001,
                               64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] ev_x  [7] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'h0000_0000_7FFF_FFFF,
                               64'hFFFF_FFFF_FFFF_8001, 64'hFFFF_FFFF_8000_0000,
                               64'h8000_0000_0000_0001, 64'h0000_0000_FFFF_FFFF};
    int          st_addr [10] = '{22, 23, 24, 25, 8, 26, 27, 28, 29, 9};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ld_a;
        bit  rdy;
        bit  hs;
        reset = 0;
        alu_valid = 0; alu_rd_addr = '0; alu_rd_data = '0;
        ld_valid = 0; ld_rd_addr = '0; ld_rd_data = '0; ld_size = '0; ld_unsigned = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_wen", reg_write_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_clear_busy", clear_busy_addr, 0);
        reset = 1;
        model_ok = 1;
        #1;
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_ld_ready", ld_ready, 1);
        cyc();

        // load extension vectors to x7
        for (int i = 0; i < 7; i++) begin
            drive_ld(5'd7, ev_d[i], ev_sz[i], ev_u[i]);
            cyc();
            ld_valid = 0;
            chk("ext_wen", reg_write_en, 1);
            chk("ext_addr", rd_addr, 7);
            chk("ext_data", rd_data, ev_x[i]);
        end
        idle(2);

        // simultaneous load and ALU
        drive_ld(5'd3, 64'h11, 2'd3, 1'b0);
        drive_alu(5'd4, 64'h22);
        cyc();
        ld_valid = 0; alu_valid = 0;
        chk("sim_addr1", rd_addr, 3);
        chk("sim_clear1", clear_busy_addr, 3);
        chk("sim_data1", rd_data, 64'h11);
        cyc();
        chk("sim_addr2", rd_addr, 4);
        chk("sim_clear2", clear_busy_addr, 4);
        chk("sim_data2", rd_data, 64'h22);
        cyc();
        chk("sim_idle_wen", reg_write_en, 0);

        // x0 writes are consumed and dropped
        drive_alu(5'd0, 64'hDEAD);
        #1;
        chk("x0_alu_ready", alu_ready, 1);
        cyc();
        alu_valid = 0;
        chk("x0_wen", reg_write_en, 0);
        chk("x0_clear", clear_busy_addr, 0);
        drive_ld(5'd0, 64'hBEEF, 2'd3, 1'b0);
        cyc();
        ld_valid = 0;
        chk("x0_ld_wen", reg_write_en, 0);
        idle(2);

        // starvation: fill FIFO with x8,x9 behind loads, x10 waits
        drive_ld(5'd20, 64'h200, 2'd3, 1'b0);
        drive_alu(5'd8, 64'h88);
        cyc();
        drive_ld(5'd21, 64'h210, 2'd3, 1'b0);
        drive_alu(5'd9, 64'h99);
        cyc();
        drive_alu(5'd10, 64'hAA);
        ld_a = 22;
        for (int i = 0; i < 10; i++) begin
            drive_ld(AW'(ld_a), 64'(ld_a * 16), 2'd3, 1'b0);
            #1;
            rdy = ld_ready;
            hs  = alu_valid && alu_ready;
            chk("stv_ld_ready", rdy, (i == 4 || i == 9) ? 0 : 1);
            cyc();
            if (hs) alu_valid = 0;
            if (rdy) ld_a++;
            chk("stv_addr", rd_addr, st_addr[i]);
        end
        cyc();
        chk("stv_last_ld", rd_addr, 30);
        idle(3);
        chk("stv_drain_wen", reg_write_en, 0);

        // asynchronous reset with two entries queued
        drive_ld(5'd1, 64'h1, 2'd3, 1'b0);
        drive_alu(5'd2, 64'h2);
        cyc();
        drive_ld(5'd3, 64'h3, 2'd3, 1'b0);
        drive_alu(5'd4, 64'h4);
        cyc();
        alu_valid = 0; ld_valid = 0;
        chk("rq_model_depth", mq.size(), 2);
        chk("rq_wen_before", reg_write_en, 1);
        #1;
        reset = 0;
        #1;
        chk("rq_wen", reg_write_en, 0);
        chk("rq_rd_addr", rd_addr, 0);
        chk("rq_rd_data", rd_data, 0);
        chk("rq_clear", clear_busy_addr, 0);
        @(posedge clk);
        #2;
        reset = 1;
        drive_alu(5'd5, 64'h55);
        cyc();
        alu_valid = 0;
        chk("rq_x5_wen", reg_write_en, 1);
        chk("rq_x5_addr", rd_addr, 5);
        chk("rq_x5_data", rd_data, 64'h55);
        cyc();
        chk("rq_empty_wen", reg_write_en, 0);

`ifdef WB_PERF_CNT_EN
        // 10 real writes plus 2 x0 writes
        #1;
        reset = 0;
        #2;
        reset = 1;
        cyc();
        for (int i = 1; i <= 12; i++) begin
            drive_alu((i == 4 || i == 9) ? AW'(0) : AW'(i), 64'(i));
            cyc();
        end
        idle(2);
        chk("perf_retired", retired_writes, 10);
`endif

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
